// File: rtl/neuron_n_pkg.sv
// Shared Q-format constants, FSM encodings and a small sizing helper for the neuron_n datapath.
package neuron_n_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FBITS_DEF = 24;

  localparam logic signed [WIDTH_DEF-1:0] Q_ONE = WIDTH_DEF'(1) << FBITS_DEF;
  localparam logic signed [WIDTH_DEF-1:0] Q_MAX = {1'b0, {(WIDTH_DEF-1){1'b1}}};
  localparam logic signed [WIDTH_DEF-1:0] Q_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_ACT  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Index register width; a single-pair neuron still needs a one-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_Q.sv
// Signed Q-format multiplier: full-precision product shifted down by FBITS, wrapped to WIDTH.
module mult_Q import neuron_n_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FBITS = FBITS_DEF
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] p_o
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0] prod;

  assign prod = PW'(a_i) * PW'(b_i);
  assign p_o  = WIDTH'(prod >>> FBITS);

endmodule

// File: rtl/neuron_n_sat_reduce.sv
// Narrows the guarded accumulator to WIDTH and flags overflow; NEURON_N_SAT_EN selects saturation over wrap.
module sat_reduce import neuron_n_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ACC_W = WIDTH_DEF + 2
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [WIDTH-1:0] red_o,
  output logic                    ovf_o
);

  localparam int HI_W = ACC_W - WIDTH + 1;

  // The value fits when every guard bit equals the WIDTH-level sign bit.
  function automatic logic fits(input logic [HI_W-1:0] hi);
    return (&hi) | ~(|hi);
  endfunction

  assign ovf_o = ~fits(acc_i[ACC_W-1:WIDTH-1]);

`ifdef NEURON_N_SAT_EN
  function automatic logic signed [WIDTH-1:0] saturate(input logic neg, input logic over,
                                                       input logic signed [WIDTH-1:0] low);
    if (!over) return low;
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign red_o = saturate(acc_i[ACC_W-1], ovf_o, acc_i[WIDTH-1:0]);
`else
  assign red_o = acc_i[WIDTH-1:0];
`endif

endmodule

// File: rtl/tanh.sv
// Odd-symmetric tanh approximation: |x| - x^2/4 below 2.0, clamped to 1.0 at and above 2.0.
module tanh import neuron_n_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FBITS = FBITS_DEF
) (
  input  logic signed [WIDTH-1:0] x_i,
  output logic signed [WIDTH-1:0] y_o
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1) << FBITS;
  localparam logic [WIDTH:0] TWO = (WIDTH+1)'(1) << (FBITS + 1);

  logic signed [WIDTH:0]   xe;
  logic        [WIDTH:0]   ax;
  logic        [WIDTH:0]   mag;
  logic        [2*WIDTH+1:0] sq;

  // One extra bit so that |most-negative| is representable.
  assign xe = {x_i[WIDTH-1], x_i};
  assign ax = xe[WIDTH] ? $unsigned(-xe) : $unsigned(xe);
  assign sq = (2*WIDTH+2)'(ax) * (2*WIDTH+2)'(ax);

  always_comb begin
    if (ax >= TWO) mag = ONE;
    else           mag = ax - (WIDTH+1)'(sq >> (FBITS + 2));
  end

  assign y_o = xe[WIDTH] ? -$signed(WIDTH'(mag)) : $signed(WIDTH'(mag));

endmodule

// File: rtl/neuron_n.sv
// Sequential neuron: one MAC per enabled cycle over N_IN pairs plus bias, then tanh.
// Reduction mode is selected by NEURON_N_SAT_EN (saturate) vs default (wrap).
module neuron_n import neuron_n_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FBITS = FBITS_DEF,
  parameter int N_IN  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WIDTH-1:0]   a_vec,
  input  logic [N_IN*WIDTH-1:0]   w_vec,
  input  logic signed [WIDTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] y,
  output logic                    ovf
);

  localparam int GW    = $clog2(N_IN + 1);
  localparam int ACC_W = WIDTH + GW;
  localparam int KW    = idx_w(N_IN);
  localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);

  logic [1:0]              state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [N_IN*WIDTH-1:0]   a_q, a_d, w_q, w_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic                    ovf_q, ovf_d;
  logic                    vld_q, vld_d;

  logic signed [WIDTH-1:0] a_sel, w_sel, prod, red, act;
  logic                    red_ovf;
  logic                    load;

  // Registered operands are walked by k, so one multiplier serves every pair.
  assign a_sel = a_q[k_q*WIDTH +: WIDTH];
  assign w_sel = w_q[k_q*WIDTH +: WIDTH];

  mult_Q #(.WIDTH(WIDTH), .FBITS(FBITS)) u_mul (
    .a_i (a_sel),
    .b_i (w_sel),
    .p_o (prod)
  );

  sat_reduce #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_red (
    .acc_i (acc_q),
    .red_o (red),
    .ovf_o (red_ovf)
  );

  tanh #(.WIDTH(WIDTH), .FBITS(FBITS)) u_tanh (
    .x_i (red),
    .y_o (act)
  );

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready);
  assign load     = en & in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    a_d     = a_q;
    w_d     = w_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    if (en) begin
      case (state_q)
        ST_MAC: begin
          acc_d = acc_q + ACC_W'(prod);
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_ACT;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        ST_ACT: begin
          y_d     = act;
          ovf_d   = red_ovf;
          vld_d   = 1'b1;
          state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            vld_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
      // A same-cycle accept in HOLD goes straight to MAC without an idle bubble.
      if (load) begin
        a_d     = a_vec;
        w_d     = w_vec;
        acc_d   = ACC_W'(b);
        k_d     = '0;
        ovf_d   = 1'b0;
        state_d = ST_MAC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      w_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      w_q     <= w_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign y         = y_q;
  assign ovf       = ovf_q;
  assign out_valid = vld_q;

endmodule

// File: doc/neuron_n.md
NEURON_N -- requirements
Module: neuron_n

Interface
REQ-001 Parameter WIDTH, default 32: data word width, signed two's complement, all data ports.
REQ-002 Parameter FBITS, default 24: fractional bits of the Q(WIDTH-FBITS).FBITS format, passed to mult_Q.
REQ-003 Parameter N_IN, default 3, legal range 1..64: number of activation/weight pairs.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  clock enable; when low all internal state and outputs hold.
REQ-007 in_valid  input  1  operand set on a_vec/w_vec/b is valid.
REQ-008 in_ready  output  1  block accepts an operand set this cycle.
REQ-009 a_vec  input  N_IN*WIDTH  activations, element k at bits [k*WIDTH +: WIDTH].
REQ-010 w_vec  input  N_IN*WIDTH  weights, same packing as a_vec.
REQ-011 b  input  WIDTH  bias.
REQ-012 out_valid  output  1  y is valid.
REQ-013 out_ready  input  1  consumer accepts y this cycle.
REQ-014 y  output  WIDTH  tanh(sum(a_k*w_k) + b), Q format.
REQ-015 ovf  output  1  accumulator left the WIDTH range during the current result; valid with out_valid.

Function
REQ-016 Transfer in occurs when in_valid & in_ready & en; transfer out occurs when out_valid & out_ready & en.
REQ-017 States: IDLE, MAC, ACT, HOLD; in_ready = (IDLE) or (HOLD and out_ready).
REQ-018 On transfer in: a_vec, w_vec captured into operand registers, accumulator loaded with b sign-extended, index k cleared, ovf cleared, go to MAC.
REQ-019 MAC: one product per enabled cycle, acc += mult_Q(a_k, w_k), k increments; after k = N_IN-1 go to ACT.
REQ-020 Accumulator width WIDTH + clog2(N_IN+1) guard bits; products are full WIDTH mult_Q results, sign-extended.
REQ-021 ACT: acc reduced to WIDTH (per REQ-029/030), passed through tanh, registered into y; out_valid set; go to HOLD.
REQ-022 Latency: out_valid rises exactly N_IN+1 enabled cycles after the transfer-in cycle.
REQ-023 HOLD: y, ovf, out_valid stable until transfer out; then IDLE, or MAC directly if a transfer in happens the same cycle (back-to-back, no bubble).
REQ-024 ovf set when the accumulator value exceeds [-2^(WIDTH-1), 2^(WIDTH-1)-1] at the ACT reduction.
REQ-025 in_valid while busy (MAC/ACT, or HOLD without out_ready) is ignored; inputs need not be held after transfer in.
REQ-026 en low freezes state, k, acc and outputs; handshakes are not evaluated.

Reset
REQ-027 rst high, at any time including mid-MAC or HOLD: state IDLE, y = 0, out_valid = 0, ovf = 0, acc = 0, k = 0, operand registers = 0; in-flight result discarded.
REQ-028 in_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-029 Macro NEURON_N_SAT_EN defined: ACT reduction saturates to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
REQ-030 NEURON_N_SAT_EN undefined: ACT reduction truncates to low WIDTH bits (wrap); ovf still reported.

Structure
REQ-031 Shared package holds Q-format constants (WIDTH, FBITS defaults, Q_ONE, Q_MAX, Q_MIN) and state encodings.
REQ-032 Reuse existing mult_Q (one instance) and tanh; single new sub-module sat_reduce performing the REQ-029/030 reduction and ovf detection.
REQ-033 Operand selection by k is a registered-operand mux; no N_IN-wide multiplier array.

Verification (N_IN=3, WIDTH=32, FBITS=24, 1.0 = 0x01000000)
REQ-034 a={1.0,0.5,-1.0}, w={0.5,1.0,0.25}, b=0 -> pre-activation 0.75 (0x00C00000), y = tanh model(0x00C00000) exactly, ovf=0, out_valid at accept+4.
REQ-035 a={100.0,100.0,100.0}, w={1.0,1.0,1.0}, b=100.0 -> ovf=1; SAT_EN: y = tanh(0x7FFFFFFF); no SAT_EN: y = tanh(0x90000000).
REQ-036 Two operand sets, out_ready held high, in_valid asserted in HOLD -> second accepted same cycle as first output, second out_valid 4 cycles later.
REQ-037 out_ready low 10 cycles in HOLD -> y/out_valid stable, in_ready=0, new in_valid ignored.
REQ-038 rst pulsed at MAC k=1 -> y=0, out_valid=0, in_ready=1 next cycle; following set computes correctly.
REQ-039 en low 5 cycles during MAC -> latency extends by exactly 5 cycles, result unchanged.
